vpu_cmd_queue: RTL and testbench

Command buffer between the CPU's VPU command port and the matrix (geometry) stage of the VPU. It captures each CPU command strobe together with its operands into a FIFO. It then replays commands to the matrix stage one at a time, each as a single-cycle `go` pulse, waiting for the previous command to finish before sending the next. It decouples CPU issue rate from VPU busy time, and its `cpu_rdy` output replaces the direct `!busy` ready signal.

---
 rtl/vpu_cmd_queue_if.sv | 42 ++++
 rtl/vpu_cmd_queue.sv | 154 +++++++++++++++
 tb/tb_vpu_cmd_queue.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_cmd_queue_if.sv
// CPU-to-VPU command port bundle: push strobe, operands and ready on the CPU side; go, operands and busy on the matrix side.
// Pure wiring, no latency of its own.
// cpu_rdy is the only backpressure toward the CPU; vpu_busy is the only feedback from the matrix stage.
interface vpu_cmd_queue_if;
   logic         cpu_start;
   logic         cpu_fill;
   logic [1:0]   cpu_obj_type;
   logic [2:0]   cpu_obj_color;
   logic [3:0]   cpu_op;
   logic [3:0]   cpu_code;
   logic [4:0]   cpu_obj_num;
   logic [127:0] cpu_v;
   logic [15:0]  cpu_ro;
   logic         cpu_rdy;

   logic         vpu_go;
   logic         vpu_fill;
   logic [1:0]   vpu_obj_type;
   logic [2:0]   vpu_obj_color;
   logic [3:0]   vpu_op;
   logic [3:0]   vpu_code;
   logic [4:0]   vpu_obj_num;
   logic [127:0] vpu_v;
   logic [15:0]  vpu_ro;
   logic         vpu_busy;

   // Command source and matrix-stage model (drives pushes and busy)
   modport master (
      output cpu_start, cpu_fill, cpu_obj_type, cpu_obj_color, cpu_op, cpu_code,
             cpu_obj_num, cpu_v, cpu_ro, vpu_busy,
      input  cpu_rdy, vpu_go, vpu_fill, vpu_obj_type, vpu_obj_color, vpu_op,
             vpu_code, vpu_obj_num, vpu_v, vpu_ro
   );

   // The queue itself
   modport slave (
      input  cpu_start, cpu_fill, cpu_obj_type, cpu_obj_color, cpu_op, cpu_code,
             cpu_obj_num, cpu_v, cpu_ro, vpu_busy,
      output cpu_rdy, vpu_go, vpu_fill, vpu_obj_type, vpu_obj_color, vpu_op,
             vpu_code, vpu_obj_num, vpu_v, vpu_ro
   );
endinterface

// File: rtl/vpu_cmd_queue.sv
// Command FIFO between the CPU VPU port and the matrix stage; replays one command at a time as a single-cycle go pulse.
// Latency: push at edge N into an empty idle queue -> operands valid from edge N+2, vpu_go high for the cycle after N+2.
// Backpressure: cpu_rdy low when full, pushes while full are dropped; next go waits for busy to fall or the busy timeout.
// Optional statistics (drop_cnt, hwm) built only when VPU_CMDQ_STATS_EN is defined; otherwise they are tied to 0.
module vpu_cmd_queue #(
   parameter int DEPTH        = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   vpu_cmd_queue_if.slave        cq,
   output logic [$clog2(DEPTH):0] level,
   output logic [7:0]            drop_cnt,
   output logic [$clog2(DEPTH):0] hwm
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 163;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          cpu_rdy_q;
   logic          not_empty_q;
   state_t        state;
   logic [3:0]    timer;
   logic          push;
   logic          pop;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] head;

   assign wr_entry = {cq.cpu_fill, cq.cpu_obj_type, cq.cpu_obj_color, cq.cpu_op,
                      cq.cpu_code, cq.cpu_obj_num, cq.cpu_v, cq.cpu_ro};
   assign head     = mem[rd_ptr];

   // Full is judged on the registered count, so a same-cycle pop never rescues a push while full.
   assign push = cq.cpu_start && (count != CW'(DEPTH));
   // not_empty_q lags count by one cycle; this gives the two-edge issue latency and is safe
   // because after a pop the FSM spends at least two cycles outside IDLE.
   assign pop  = (state == S_IDLE) && not_empty_q;

   assign level      = count;
   assign cq.cpu_rdy = cpu_rdy_q;

   // Next entry count from this cycle's push/pop pair
   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CW'(1);
      else if (!push && pop)
         count_nxt = count - CW'(1);
   end

   // Entry storage; written only on accepted pushes
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_entry;
   end

   // Pointers, count and the registered ready/not-empty flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         cpu_rdy_q   <= 1'b1;
         not_empty_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count       <= count_nxt;
         cpu_rdy_q   <= (count_nxt != CW'(DEPTH));
         not_empty_q <= (count != '0);
      end
   end

   // Issue FSM: pop into operand registers, pulse go, then wait for busy or the timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         timer            <= '0;
         cq.vpu_go        <= 1'b0;
         cq.vpu_fill      <= 1'b0;
         cq.vpu_obj_type  <= '0;
         cq.vpu_obj_color <= '0;
         cq.vpu_op        <= '0;
         cq.vpu_code      <= '0;
         cq.vpu_obj_num   <= '0;
         cq.vpu_v         <= '0;
         cq.vpu_ro        <= '0;
      end else begin
         cq.vpu_go <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  {cq.vpu_fill, cq.vpu_obj_type, cq.vpu_obj_color, cq.vpu_op,
                   cq.vpu_code, cq.vpu_obj_num, cq.vpu_v, cq.vpu_ro} <= head;
                  cq.vpu_go <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (cq.vpu_busy) begin
                  state <= S_WAIT_DONE;
               end else begin
                  timer <= timer + 4'd1;
                  // Ops such as fill never raise busy; give up after the timeout
                  if (timer + 4'd1 == 4'(BUSY_TIMEOUT))
                     state <= S_IDLE;
               end
            end
            S_WAIT_DONE: begin
               if (!cq.vpu_busy)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef VPU_CMDQ_STATS_EN
   // Saturating drop counter and high-water mark of the entry count
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
         hwm      <= '0;
      end else begin
         if (cq.cpu_start && !push && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
         if (count_nxt > hwm)
            hwm <= count_nxt;
      end
   end
`else
   assign drop_cnt = '0;
   assign hwm      = '0;
`endif

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// Bench for vpu_cmd_queue: directed scenarios plus randomized traffic scored against a queue-based model.
// The model tracks accepted pushes in order and the expected entry count from push strobes and observed go pulses.
// Works for both the default and the statistics build.
module tb_vpu_cmd_queue;
   localparam int DEPTH = 4;
   localparam int BT    = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef VPU_CMDQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef logic [162:0] ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] level;
   logic [CW-1:0] hwm;
   logic [7:0]    drop_cnt;

   vpu_cmd_queue_if cq();

   vpu_cmd_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
      .clk(clk), .rst(rst), .cq(cq), .level(level), .drop_cnt(drop_cnt), .hwm(hwm)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   ent_t exp_q[$];
   ent_t got_q[$];
   int   mcnt = 0, mdrop = 0, mhwm = 0, dbl_go = 0;
   logic p_start = 1'b0, p_rst = 1'b1, prev_go = 1'b0;
   ent_t p_ent;

   function automatic ent_t vpu_ent();
      return {cq.vpu_fill, cq.vpu_obj_type, cq.vpu_obj_color, cq.vpu_op,
              cq.vpu_code, cq.vpu_obj_num, cq.vpu_v, cq.vpu_ro};
   endfunction

   function automatic ent_t rand_ent();
      return ent_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
   endfunction

   task automatic apply_ent(input ent_t e);
      {cq.cpu_fill, cq.cpu_obj_type, cq.cpu_obj_color, cq.cpu_op,
       cq.cpu_code, cq.cpu_obj_num, cq.cpu_v, cq.cpu_ro} = e;
   endtask

   // Capture what the queue sees at each rising edge
   always @(posedge clk) begin
      p_start = cq.cpu_start;
      p_rst   = rst;
      p_ent   = {cq.cpu_fill, cq.cpu_obj_type, cq.cpu_obj_color, cq.cpu_op,
                 cq.cpu_code, cq.cpu_obj_num, cq.cpu_v, cq.cpu_ro};
   end

   // Model update: a go pulse means the head left at the previous edge
   always @(negedge clk) begin
      bit acc;
      if (p_rst) begin
         mcnt = 0; mdrop = 0; mhwm = 0; prev_go = 1'b0;
      end else begin
         acc = p_start && (mcnt != DEPTH);
         if (p_start && !acc && mdrop < 255) mdrop++;
         if (cq.vpu_go === 1'b1) begin
            got_q.push_back(vpu_ent());
            mcnt--;
            if (prev_go) dbl_go++;
         end
         if (acc) begin
            exp_q.push_back(p_ent);
            mcnt++;
         end
         if (mcnt > mhwm) mhwm = mcnt;
         prev_go = cq.vpu_go;
      end
   end

   // All tasks start and end just after a rising edge
   task automatic push_one(input ent_t e);
      apply_ent(e);
      cq.cpu_start = 1'b1;
      @(posedge clk); #1;
      cq.cpu_start = 1'b0;
   endtask

   task automatic wait_go(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cq.vpu_go === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic drain(output bit ok);
      cq.vpu_busy  = 1'b0;
      cq.cpu_start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (mcnt == 0 && level == 0 && got_q.size() == exp_q.size()) begin ok = 1'b1; break; end
      end
      repeat (BT + 4) @(posedge clk);
      #1;
   endtask

   task automatic hold_busy_after_go(input string nm);
      bit ok;
      wait_go(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL %s first go not seen within 10 cycles", nm); end
      @(posedge clk); #1;
      cq.vpu_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (level !== 0) begin errors++; $display("FAIL reset level got %0d want 0", level); end
      checks++; if (cq.cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset cpu_rdy got %b want 1", cq.cpu_rdy); end
      checks++; if (cq.vpu_go !== 1'b0) begin errors++; $display("FAIL reset vpu_go got %b want 0", cq.vpu_go); end
      checks++; if (vpu_ent() !== '0) begin errors++; $display("FAIL reset operands got %h want 0", vpu_ent()); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset drop_cnt got %0d want 0", drop_cnt); end
      checks++; if (hwm !== 0) begin errors++; $display("FAIL reset hwm got %0d want 0", hwm); end
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      ent_t e;
      exp_q.delete(); got_q.delete();
      e = rand_ent();
      e[143:16] = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
      push_one(e);
      @(negedge clk);
      checks++; if (cq.vpu_go !== 1'b0) begin errors++; $display("FAIL single go after N got %b want 0", cq.vpu_go); end
      @(negedge clk);
      checks++; if (cq.vpu_go !== 1'b0) begin errors++; $display("FAIL single go after N+1 got %b want 0", cq.vpu_go); end
      @(negedge clk);
      checks++; if (cq.vpu_go !== 1'b1) begin errors++; $display("FAIL single go after N+2 got %b want 1", cq.vpu_go); end
      checks++; if (cq.vpu_v !== e[143:16]) begin errors++; $display("FAIL single vpu_v got %h want %h", cq.vpu_v, e[143:16]); end
      @(negedge clk);
      checks++; if (cq.vpu_go !== 1'b0) begin errors++; $display("FAIL single go width got %b want 0", cq.vpu_go); end
      repeat (BT + 3) @(negedge clk);
      #1;
      checks++; if (got_q.size() != 1 || level !== 0) begin errors++; $display("FAIL single issue count got %0d level %0d want 1 and 0", got_q.size(), level); end
      checks++; if (vpu_ent() !== e) begin errors++; $display("FAIL single operands held got %h want %h", vpu_ent(), e); end
      @(posedge clk); #1;
   endtask

   task automatic test_busy;
      ent_t e1, e2;
      bit ok, seen;
      exp_q.delete(); got_q.delete();
      e1 = rand_ent(); e2 = rand_ent();
      push_one(e1);
      push_one(e2);
      wait_go(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy first go not seen within 10 cycles"); end
      @(posedge clk); #1;
      cq.vpu_busy = 1'b1;
      seen = 1'b0;
      repeat (10) begin @(negedge clk); if (cq.vpu_go === 1'b1) seen = 1'b1; end
      @(posedge clk); #1;
      cq.vpu_busy = 1'b0;
      checks++; if (seen) begin errors++; $display("FAIL busy go while busy got 1 want 0"); end
      @(negedge clk);
      checks++; if (cq.vpu_go !== 1'b0) begin errors++; $display("FAIL busy early go got %b want 0", cq.vpu_go); end
      wait_go(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy second go not seen after busy fell"); end
      @(posedge clk); #1;
      drain(ok);
      checks++; if (!ok || got_q.size() != 2) begin errors++; $display("FAIL busy issued got %0d want 2", got_q.size()); end
      checks++; if (got_q[0] !== e1 || got_q[1] !== e2) begin errors++; $display("FAIL busy order got %h,%h want %h,%h", got_q[0], got_q[1], e1, e2); end
   endtask

   task automatic test_overflow;
      ent_t e;
      bit ok;
      exp_q.delete(); got_q.delete();
      push_one(rand_ent());
      hold_busy_after_go("overflow");
      for (int k = 1; k <= 6; k++) begin
         e = rand_ent(); e[148:144] = 5'(k);
         apply_ent(e);
         cq.cpu_start = 1'b1;
         @(posedge clk); #1;
      end
      cq.cpu_start = 1'b0;
      @(negedge clk);
      checks++; if (level !== DEPTH) begin errors++; $display("FAIL overflow level got %0d want %0d", level, DEPTH); end
      checks++; if (cq.cpu_rdy !== 1'b0) begin errors++; $display("FAIL overflow cpu_rdy got %b want 0", cq.cpu_rdy); end
      checks++; if (drop_cnt !== (STATS ? 8'd2 : 8'd0)) begin errors++; $display("FAIL overflow drop_cnt got %0d want %0d", drop_cnt, STATS ? 2 : 0); end
      checks++; if (hwm !== (STATS ? CW'(DEPTH) : CW'(0))) begin errors++; $display("FAIL overflow hwm got %0d want %0d", hwm, STATS ? DEPTH : 0); end
      @(posedge clk); #1;
      drain(ok);
      checks++; if (!ok || got_q.size() != 5) begin errors++; $display("FAIL overflow issued got %0d want 5", got_q.size()); end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (got_q[k][148:144] !== 5'(k)) begin errors++; $display("FAIL overflow order slot %0d obj_num got %0d want %0d", k, got_q[k][148:144], k); end
      end
   endtask

   task automatic test_wrap;
      ent_t e;
      bit ok;
      int n = 0;
      exp_q.delete(); got_q.delete();
      for (int it = 0; it < 10; it++) begin
         for (int j = 0; j < 3; j++) begin
            e = rand_ent(); e[148:144] = 5'(n); n++;
            apply_ent(e);
            cq.cpu_start = 1'b1;
            @(posedge clk); #1;
         end
         drain(ok);
         checks++; if (!ok) begin errors++; $display("FAIL wrap drain round %0d level %0d want 0", it, level); end
      end
      checks++; if (got_q.size() != 30 || level !== 0) begin errors++; $display("FAIL wrap issued got %0d level %0d want 30 and 0", got_q.size(), level); end
      for (int i = 0; i < 30; i++) begin
         checks++;
         if (got_q[i][148:144] !== 5'(i)) begin errors++; $display("FAIL wrap order i=%0d obj_num got %0d want %0d", i, got_q[i][148:144], 5'(i)); end
      end
   endtask

   task automatic test_simul;
      ent_t d, a, b, c;
      bit ok;
      exp_q.delete(); got_q.delete();
      d = rand_ent(); a = rand_ent(); b = rand_ent(); c = rand_ent();
      push_one(d);
      hold_busy_after_go("simul");
      push_one(a);
      push_one(b);
      cq.vpu_busy = 1'b0;
      @(posedge clk); #1;
      apply_ent(c);
      cq.cpu_start = 1'b1;
      @(posedge clk); #1;
      cq.cpu_start = 1'b0;
      @(negedge clk);
      checks++; if (cq.vpu_go !== 1'b1) begin errors++; $display("FAIL simul pop edge go got %b want 1", cq.vpu_go); end
      checks++; if (level !== 2) begin errors++; $display("FAIL simul level got %0d want 2", level); end
      @(posedge clk); #1;
      drain(ok);
      checks++; if (!ok || got_q.size() != 4) begin errors++; $display("FAIL simul issued got %0d want 4", got_q.size()); end
      checks++; if (got_q[1] !== a || got_q[2] !== b || got_q[3] !== c) begin errors++; $display("FAIL simul order got %h,%h,%h want %h,%h,%h", got_q[1], got_q[2], got_q[3], a, b, c); end
   endtask

   task automatic test_reset_mid;
      ent_t e;
      bit ok;
      exp_q.delete(); got_q.delete();
      push_one(rand_ent());
      hold_busy_after_go("reset_mid");
      for (int k = 0; k < 3; k++) push_one(rand_ent());
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cq.vpu_busy = 1'b0;
      @(negedge clk);
      checks++; if (level !== 0) begin errors++; $display("FAIL reset_mid level got %0d want 0", level); end
      checks++; if (cq.vpu_go !== 1'b0) begin errors++; $display("FAIL reset_mid go got %b want 0", cq.vpu_go); end
      checks++; if (vpu_ent() !== '0) begin errors++; $display("FAIL reset_mid operands got %h want 0", vpu_ent()); end
      checks++; if (cq.cpu_rdy !== 1'b1 || hwm !== 0) begin errors++; $display("FAIL reset_mid rdy/hwm got %b/%0d want 1/0", cq.cpu_rdy, hwm); end
      @(posedge clk); #1;
      exp_q.delete(); got_q.delete();
      e = rand_ent();
      push_one(e);
      drain(ok);
      checks++; if (!ok || got_q.size() != 1 || got_q[0] !== e) begin errors++; $display("FAIL reset_mid new push got %0d entries first %h want 1 entry %h", got_q.size(), got_q[0], e); end
   endtask

   task automatic test_random;
      bit ok;
      int bad = 0;
      exp_q.delete(); got_q.delete();
      for (int i = 0; i < 400; i++) begin
         apply_ent(rand_ent());
         cq.cpu_start = ($urandom_range(0, 99) < 45);
         cq.vpu_busy  = ($urandom_range(0, 99) < 30);
         @(negedge clk); #1;
         checks++;
         if (level !== CW'(mcnt) || cq.cpu_rdy !== (mcnt != DEPTH)) begin
            errors++; bad++;
            if (bad < 5) $display("FAIL random level/rdy cycle %0d got %0d/%b want %0d/%b", i, level, cq.cpu_rdy, mcnt, mcnt != DEPTH);
         end
         @(posedge clk); #1;
      end
      drain(ok);
      checks++; if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL random issued got %0d want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random order i=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (dbl_go != 0) begin errors++; $display("FAIL random go pulse wider than one cycle count %0d want 0", dbl_go); end
      checks++; if (drop_cnt !== (STATS ? 8'(mdrop) : 8'd0)) begin errors++; $display("FAIL random drop_cnt got %0d want %0d", drop_cnt, STATS ? mdrop : 0); end
      checks++; if (hwm !== (STATS ? CW'(mhwm) : CW'(0))) begin errors++; $display("FAIL random hwm got %0d want %0d", hwm, STATS ? mhwm : 0); end
   endtask

   initial begin
      rst = 1'b1;
      cq.cpu_start = 1'b0;
      cq.vpu_busy  = 1'b0;
      apply_ent('0);
      test_reset();
      test_single();
      test_busy();
      test_overflow();
      test_wrap();
      test_simul();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Backstop so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog expired checks %0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
